// File: rtl/int_ack_controller.sv
// int_ack_controller: interrupt acknowledge sequencer for an 8259-style core.
// Picks the highest-priority eligible request, raises INT, and walks the
// 8086-mode two-pulse INTA cycle: clears the served IRR bit, freezes the IRR,
// sets the ISR bit and drives the vector. Also handles normal, specific and
// automatic EOI, with optional priority rotation.
module int_ack_controller #(
    parameter int NUM_IR     = 8,
    parameter int SPUR_LEVEL = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_IR-1:0] irr_in,
    input  logic [NUM_IR-1:0] imr,
    input  logic              inta_n,
    input  logic [4:0]        vector_base,
    input  logic              aeoi,
    input  logic              rotate,
    input  logic              eoi_cmd,
    input  logic              eoi_specific,
    input  logic [2:0]        eoi_level,
    output logic              int_out,
    output logic [NUM_IR-1:0] clear_irr,
    output logic              freeze,
    output logic [NUM_IR-1:0] isr,
    output logic [7:0]        vector_out,
    output logic              vector_oe
);

    localparam logic [2:0] SPUR_LVL = 3'(SPUR_LEVEL);

    typedef enum logic [1:0] {IDLE, CLR, ACK1, ACK2} state_t;

    state_t            state, state_nxt;
    logic              inta_d;
    logic [2:0]        lowest_prio;
    logic [2:0]        lvl;
    logic              spur;

    logic              fall, rise;
    logic [NUM_IR-1:0] pending;
    logic              win_found, top_found, eligible;
    logic [2:0]        win_lvl, top_lvl;

    logic              int_nxt, frz_nxt, oe_nxt, spur_nxt;
    logic [NUM_IR-1:0] clr_nxt, isr_nxt, isr_set, isr_clr;
    logic [7:0]        vec_nxt;
    logic [2:0]        lvl_nxt, lowp_nxt, eoi_lvl;

    // One-hot decode of a level.
    function automatic logic [NUM_IR-1:0] onehot(input logic [2:0] l);
        logic [NUM_IR-1:0] r;
        r    = '0;
        r[l] = 1'b1;
        return r;
    endfunction

    // First set bit scanning circularly from lowp+1; returns {found, level}.
    function automatic logic [3:0] first_set(input logic [NUM_IR-1:0] v, input logic [2:0] lowp);
        logic [2:0] c;
        logic       found;
        logic [2:0] sel;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < 8; k++) begin
            c = lowp + 3'd1 + 3'(k);
            if (!found && v[c]) begin
                found = 1'b1;
                sel   = c;
            end
        end
        return {found, sel};
    endfunction

    // Priority rank of a level: 0 is the highest priority.
    function automatic logic [2:0] rank_of(input logic [2:0] l, input logic [2:0] lowp);
        return l - lowp - 3'd1;
    endfunction

    assign fall    = inta_d & ~inta_n;
    assign rise    = ~inta_d & inta_n;
    assign pending = irr_in & ~imr;

    assign {win_found, win_lvl} = first_set(pending, lowest_prio);
    assign {top_found, top_lvl} = first_set(isr, lowest_prio);

    // Fully nested: a request must outrank every in-service level.
    assign eligible = win_found &&
                      (!top_found || (rank_of(win_lvl, lowest_prio) < rank_of(top_lvl, lowest_prio)));

    // State and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            inta_d      <= 1'b1;
            lowest_prio <= 3'd7;
            lvl         <= '0;
            spur        <= 1'b0;
            int_out     <= 1'b0;
            clear_irr   <= '0;
            freeze      <= 1'b0;
            isr         <= '0;
            vector_out  <= '0;
            vector_oe   <= 1'b0;
        end else begin
            state       <= state_nxt;
            inta_d      <= inta_n;
            lowest_prio <= lowp_nxt;
            lvl         <= lvl_nxt;
            spur        <= spur_nxt;
            int_out     <= int_nxt;
            clear_irr   <= clr_nxt;
            freeze      <= frz_nxt;
            isr         <= isr_nxt;
            vector_out  <= vec_nxt;
            vector_oe   <= oe_nxt;
        end
    end

    // Next-state sequencing through the two INTA pulses.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fall) state_nxt = CLR;
            CLR:     state_nxt = ACK1;
            ACK1:    if (fall) state_nxt = ACK2;
            ACK2:    if (rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs, ISR and priority pointer.
    always_comb begin
        int_nxt  = 1'b0;
        clr_nxt  = '0;
        frz_nxt  = freeze;
        vec_nxt  = vector_out;
        oe_nxt   = vector_oe;
        lvl_nxt  = lvl;
        spur_nxt = spur;
        lowp_nxt = lowest_prio;
        isr_set  = '0;
        isr_clr  = '0;
        eoi_lvl  = eoi_specific ? eoi_level : top_lvl;

        case (state)
            IDLE: begin
                int_nxt = eligible;
                if (fall) begin
                    int_nxt = 1'b0;
                    if (eligible) begin
                        lvl_nxt  = win_lvl;
                        spur_nxt = 1'b0;
                        clr_nxt  = onehot(win_lvl);
                        isr_set  = onehot(win_lvl);
                    end else begin
                        lvl_nxt  = SPUR_LVL;
                        spur_nxt = 1'b1;
                    end
                end
            end
            // The clear pulse lands while freeze is still low, since freeze
            // overrides clear inside the IRR.
            CLR: frz_nxt = 1'b1;
            ACK1: begin
                if (fall) begin
                    vec_nxt = {vector_base, lvl};
                    oe_nxt  = 1'b1;
                end
            end
            ACK2: begin
                if (rise) begin
                    oe_nxt  = 1'b0;
                    frz_nxt = 1'b0;
                    // A spurious acknowledge never set an ISR bit, so nothing to retire.
                    if (aeoi && !spur) begin
                        isr_clr = onehot(lvl);
                        if (rotate) lowp_nxt = lvl;
                    end
                end
            end
            default: ;
        endcase

        // EOI is honoured in every state; clearing a clear bit is a no-op.
        if (eoi_cmd && isr[eoi_lvl]) begin
            isr_clr = isr_clr | onehot(eoi_lvl);
            if (rotate) lowp_nxt = eoi_lvl;
        end

        // Set wins over clear on the same bit.
        isr_nxt = (isr & ~isr_clr) | isr_set;
    end

endmodule

// File: tb/tb_int_ack_controller.sv
// Directed bench for int_ack_controller: a cycle table for the basic
// acknowledge / EOI / spurious flow plus hand-written multi-cycle sequences.
module tb_int_ack_controller;

    logic       clk;
    logic       reset;
    logic [7:0] irr_in, imr;
    logic       inta_n;
    logic [4:0] vector_base;
    logic       aeoi, rotate, eoi_cmd, eoi_specific;
    logic [2:0] eoi_level;
    logic       int_out, freeze, vector_oe;
    logic [7:0] clear_irr, isr, vector_out;

    int n_checks = 0;
    int n_fail   = 0;

    int_ack_controller dut (
        .clk(clk), .reset(reset), .irr_in(irr_in), .imr(imr), .inta_n(inta_n),
        .vector_base(vector_base), .aeoi(aeoi), .rotate(rotate), .eoi_cmd(eoi_cmd),
        .eoi_specific(eoi_specific), .eoi_level(eoi_level), .int_out(int_out),
        .clear_irr(clear_irr), .freeze(freeze), .isr(isr), .vector_out(vector_out),
        .vector_oe(vector_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] irr;
        logic [7:0] msk;
        logic       inta;
        logic       eoi;
        logic       spec;
        logic [2:0] elvl;
        logic       e_int;
        logic [7:0] e_clr;
        logic       e_frz;
        logic [7:0] e_isr;
        logic [7:0] e_vec;
        logic       e_oe;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic [7:0] irr, input logic [7:0] msk,
                                input logic inta, input logic eoi, input logic spec,
                                input logic [2:0] elvl, input logic e_int, input logic [7:0] e_clr,
                                input logic e_frz, input logic [7:0] e_isr, input logic [7:0] e_vec,
                                input logic e_oe);
        vec_t v;
        v.rst = rst;  v.irr = irr;  v.msk = msk;  v.inta = inta;
        v.eoi = eoi;  v.spec = spec; v.elvl = elvl;
        v.e_int = e_int; v.e_clr = e_clr; v.e_frz = e_frz;
        v.e_isr = e_isr; v.e_vec = e_vec; v.e_oe = e_oe;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic e_int, input logic [7:0] e_clr,
                             input logic e_frz, input logic [7:0] e_isr, input logic [7:0] e_vec,
                             input logic e_oe);
        check1({tag, " int_out"}, int_out, e_int);
        check8({tag, " clear_irr"}, clear_irr, e_clr);
        check1({tag, " freeze"}, freeze, e_frz);
        check8({tag, " isr"}, isr, e_isr);
        check8({tag, " vector_out"}, vector_out, e_vec);
        check1({tag, " vector_oe"}, vector_oe, e_oe);
    endtask

    initial begin
        vector_base  = 5'h11;   // vector = 8'h88 | level
        reset        = 1'b1;
        irr_in       = '0;
        imr          = '0;
        inta_n       = 1'b1;
        aeoi         = 1'b0;
        rotate       = 1'b0;
        eoi_cmd      = 1'b0;
        eoi_specific = 1'b0;
        eoi_level    = '0;

        //            rst irr    imr    inta eoi sp lvl  int clr    frz isr    vec    oe
        tbl.push_back(mk(1, 8'h00, 8'h00, 1, 0, 0, 3'd0, 0, 8'h00, 0, 8'h00, 8'h00, 0)); // reset
        tbl.push_back(mk(0, 8'h14, 8'h00, 1, 0, 0, 3'd0, 1, 8'h00, 0, 8'h00, 8'h00, 0)); // IR2 wins
        tbl.push_back(mk(0, 8'h14, 8'h00, 0, 0, 0, 3'd0, 0, 8'h04, 0, 8'h04, 8'h00, 0)); // 1st fall
        tbl.push_back(mk(0, 8'h14, 8'h00, 0, 0, 0, 3'd0, 0, 8'h00, 1, 8'h04, 8'h00, 0)); // CLR
        tbl.push_back(mk(0, 8'h14, 8'h00, 1, 0, 0, 3'd0, 0, 8'h00, 1, 8'h04, 8'h00, 0)); // rise ignored
        tbl.push_back(mk(0, 8'h14, 8'h00, 0, 0, 0, 3'd0, 0, 8'h00, 1, 8'h04, 8'h8A, 1)); // 2nd fall
        tbl.push_back(mk(0, 8'h14, 8'h00, 0, 0, 0, 3'd0, 0, 8'h00, 1, 8'h04, 8'h8A, 1)); // hold
        tbl.push_back(mk(0, 8'h14, 8'h00, 1, 0, 0, 3'd0, 0, 8'h00, 0, 8'h04, 8'h8A, 0)); // rise
        tbl.push_back(mk(0, 8'h10, 8'h00, 1, 0, 0, 3'd0, 0, 8'h00, 0, 8'h04, 8'h8A, 0)); // IR4 blocked
        tbl.push_back(mk(0, 8'h10, 8'h00, 1, 1, 0, 3'd0, 0, 8'h00, 0, 8'h00, 8'h8A, 0)); // nonspec EOI
        tbl.push_back(mk(0, 8'h10, 8'h00, 1, 0, 0, 3'd0, 1, 8'h00, 0, 8'h00, 8'h8A, 0)); // IR4 now
        tbl.push_back(mk(0, 8'hFF, 8'hFF, 1, 0, 0, 3'd0, 0, 8'h00, 0, 8'h00, 8'h8A, 0)); // all masked
        tbl.push_back(mk(0, 8'h08, 8'h00, 1, 0, 0, 3'd0, 1, 8'h00, 0, 8'h00, 8'h8A, 0)); // IR3
        tbl.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 3'd0, 0, 8'h00, 0, 8'h00, 8'h8A, 0)); // spurious fall
        tbl.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 3'd0, 0, 8'h00, 1, 8'h00, 8'h8A, 0)); // CLR
        tbl.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 3'd0, 0, 8'h00, 1, 8'h00, 8'h8A, 0)); // ACK1
        tbl.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 3'd0, 0, 8'h00, 1, 8'h00, 8'h8F, 1)); // vector 7
        tbl.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 3'd0, 0, 8'h00, 0, 8'h00, 8'h8F, 0)); // done

        for (int i = 0; i < tbl.size(); i++) begin
            reset        = tbl[i].rst;
            irr_in       = tbl[i].irr;
            imr          = tbl[i].msk;
            inta_n       = tbl[i].inta;
            eoi_cmd      = tbl[i].eoi;
            eoi_specific = tbl[i].spec;
            eoi_level    = tbl[i].elvl;
            step();
            check_all($sformatf("row%0d", i), tbl[i].e_int, tbl[i].e_clr, tbl[i].e_frz,
                      tbl[i].e_isr, tbl[i].e_vec, tbl[i].e_oe);
        end
        eoi_cmd = 1'b0;

        // AEOI with rotation: IR0 served, then IR7 outranks IR0.
        reset = 1'b1; step(); reset = 1'b0;
        aeoi = 1'b1; rotate = 1'b1; irr_in = 8'h01;
        step();            check1("rot int", int_out, 1'b1);
        inta_n = 1'b0; step(); check8("rot clr0", clear_irr, 8'h01);
                               check8("rot isr0", isr, 8'h01);
        irr_in = 8'h00; step();
        inta_n = 1'b1; step();
        inta_n = 1'b0; step(); check8("rot vec0", vector_out, 8'h88);
        inta_n = 1'b1; step(); check8("rot aeoi isr", isr, 8'h00);
                               check1("rot oe off", vector_oe, 1'b0);
        irr_in = 8'h81; step(); check1("rot int2", int_out, 1'b1);
        inta_n = 1'b0; step(); check8("rot clr7", clear_irr, 8'h80);
        irr_in = 8'h00; step();
        inta_n = 1'b1; step();
        inta_n = 1'b0; step(); check8("rot vec7", vector_out, 8'h8F);
        inta_n = 1'b1; step(); check8("rot isr7 aeoi", isr, 8'h00);
        aeoi = 1'b0; rotate = 1'b0;

        // Specific EOI of the level being acknowledged, during ACK1.
        reset = 1'b1; step(); reset = 1'b0;
        irr_in = 8'h20; step(); check1("seoi int", int_out, 1'b1);
        inta_n = 1'b0; step(); check8("seoi isr set", isr, 8'h20);
        irr_in = 8'h00; step(); check1("seoi freeze", freeze, 1'b1);
        inta_n = 1'b1; eoi_cmd = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd5;
        step();            check8("seoi isr clr", isr, 8'h00);
        eoi_cmd = 1'b0; eoi_specific = 1'b0;
        inta_n = 1'b0; step(); check8("seoi vec", vector_out, 8'h8D);
                               check1("seoi oe", vector_oe, 1'b1);
        inta_n = 1'b1; step(); check1("seoi done oe", vector_oe, 1'b0);
                               check1("seoi done frz", freeze, 1'b0);

        // Reset while the vector is on the bus.
        reset = 1'b1; step(); reset = 1'b0;
        irr_in = 8'h02; step();
        inta_n = 1'b0; step();
        step();
        inta_n = 1'b1; step();
        inta_n = 1'b0; step(); check1("rst pre oe", vector_oe, 1'b1);
                               check8("rst pre vec", vector_out, 8'h89);
        reset = 1'b1; step();
        check_all("rst mid", 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
        reset = 1'b0; inta_n = 1'b1;
        step();            check1("rst idle int", int_out, 1'b1);
        inta_n = 1'b0; step(); check8("rst idle clr", clear_irr, 8'h02);
                               check8("rst idle isr", isr, 8'h02);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
